// File: rtl/adder_result_fifo.sv
// Result buffer sitting directly behind the synchronous adder.
// Captures {carry,sum} on every adder valid and presents the oldest entry
// first-word-fall-through over a valid/ready handshake. The adder cannot be
// stalled, so a push into a full buffer (without a same-cycle pop) is dropped
// and recorded in a sticky overflow flag.
// All outputs come straight from flops. The next head word is computed
// one cycle ahead so that out_data is registered but still shows a word
// on the cycle after it was pushed.

module adder_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH:0]             in_sum,
    input  logic                       in_valid,
    output logic [WIDTH:0]             out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [WIDTH:0] DATA_ZERO = {(WIDTH + 1){1'b0}};

    // Storage array; contents are not reset, only the pointers/count are.
    logic [WIDTH:0]  mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            out_valid_q, out_valid_d;
    logic [WIDTH:0]  out_data_q, out_data_d;
    logic            overflow_q, overflow_d;

    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            head_from_in_s;

    // Handshake decode: a pop frees a slot, so a full buffer still accepts
    // a push in the same cycle it is being read.
    always_comb begin
        pop_s  = out_valid_q && out_ready;
        push_s = in_valid && (!full_q || pop_s);
        drop_s = in_valid && !push_s;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d     = (count_d == CNT_ZERO);
        full_d      = (count_d == CNT_FULL);
        out_valid_d = !empty_d;
    end

    // Next head word. When the buffer will hold exactly the word being
    // written this cycle, it is not in the array yet, so bypass in_sum.
    always_comb begin
        head_from_in_s = push_s &&
                         ((count_q == CNT_ZERO) || (pop_s && (count_q == CNT_ONE)));

        if (empty_d) begin
            out_data_d = DATA_ZERO;
        end else if (head_from_in_s) begin
            out_data_d = in_sum;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_comb begin
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= CNT_ZERO;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= DATA_ZERO;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Array write; nothing is stored while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_q[wr_ptr_q] <= in_sum;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo (WIDTH=8, DEPTH=8).
// A queue holds the words the buffer should contain; the drive task applies
// one cycle of stimulus and updates the queue from the handshake rules, and
// each scenario task compares the DUT outputs against the queue head.

module tb_adder_result_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH:0]   in_sum;
    logic             in_valid;
    logic [WIDTH:0]   out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clear_ovf;

    int               errors;
    int               checks;
    logic [WIDTH:0]   sb[$];
    logic             ovf_m;

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; model updated from the pre-edge state.
    task automatic drive(input logic v, input logic [WIDTH:0] d,
                         input logic rdy, input logic clr);
        logic full_m, pop_m, push_m;
        full_m = (sb.size() == DEPTH);
        pop_m  = (sb.size() != 0) && rdy;
        push_m = v && (!full_m || pop_m);
        in_valid  = v;
        in_sum    = d;
        out_ready = rdy;
        clear_ovf = clr;
        @(posedge clk);
        #1;
        if (pop_m) void'(sb.pop_front());
        if (push_m) sb.push_back(d);
        if (v && !push_m) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b1;          // must be ignored during reset
        in_sum   = 9'h0AA;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        sb.delete();
        ovf_m = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (count !== 4'd0)     begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_single_pass();
        drive(1'b1, 9'h1FE, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 9'h1FE) begin errors++; $display("FAIL single_data got=%h exp=1fe", out_data); end
        checks++; if (count !== 4'd1)      begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
        checks++; if (count !== 4'd0)      begin errors++; $display("FAIL single_count0 got=%0d exp=0", count); end
        checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL single_data0 got=%h exp=000", out_data); end
        // out_ready while empty moves nothing
        drive(1'b0, 9'h000, 1'b1, 1'b0);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL ready_empty count=%0d empty=%b exp=0/1", count, empty); end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== sb[0]) begin
                errors++;
                $display("FAIL %s_drain got=%h/v%b exp=%h/v1", tag, out_data, out_valid, sb[0]);
            end
            drive(1'b0, 9'h000, 1'b1, 1'b0);
            guard++;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL %s_drained_empty got=%b exp=1", tag, empty); end
    endtask

    task automatic test_fill_overflow();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 9'(k), 1'b0, 1'b0);
            if (k == 8) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
            end
        end
        checks++; if (overflow !== ovf_m || ovf_m !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", count); end
        checks++; if (out_data !== 9'd1) begin errors++; $display("FAIL fill_head got=%h exp=001", out_data); end
        drain("fill");
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_kept got=%b exp=1", overflow); end
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 10; k <= 17; k++) drive(1'b1, 9'(k), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || out_data !== 9'd10) begin errors++; $display("FAIL fpp_pre full=%b data=%h exp=1/00a", full, out_data); end
        drive(1'b1, 9'd18, 1'b1, 1'b0);
        checks++; if (count !== 4'd8)     begin errors++; $display("FAIL fpp_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
        checks++; if (out_data !== 9'd11) begin errors++; $display("FAIL fpp_head got=%h exp=00b", out_data); end
        checks++; if (sb[DEPTH-1] !== 9'd18) begin errors++; $display("FAIL fpp_model_tail got=%h exp=012", sb[DEPTH-1]); end
        drain("fpp");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) begin
            if (sb.size() != 0) begin
                checks++;
                if (out_data !== sb[0] || out_data !== 9'(k - 1)) begin
                    errors++;
                    $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, 9'(k - 1));
                end
            end
            drive(1'b1, 9'(k), 1'b1, 1'b0);
            checks++;
            if (count > 4'd1 || count !== 4'(sb.size())) begin
                errors++;
                $display("FAIL stream_count k=%0d got=%0d exp=%0d", k, count, sb.size());
            end
        end
        checks++; if (out_data !== 9'd19) begin errors++; $display("FAIL stream_last got=%h exp=013", out_data); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL stream_overflow got=%b exp=0", overflow); end
        drain("stream");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) drive(1'b1, 9'(9'h100 + k), 1'b0, 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count5 got=%0d exp=5", count); end
        do_reset(1);
        checks++; if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset count=%0d empty=%b valid=%b exp=0/1/0", count, empty, out_valid);
        end
        for (int k = 0; k < 8; k++) drive(1'b1, 9'(9'h150 + k), 1'b0, 1'b0);
        checks++; if (out_data !== 9'h150) begin errors++; $display("FAIL mid_head got=%h exp=150", out_data); end
        drive(1'b1, 9'h0FF, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1 || ovf_m !== 1'b1) begin errors++; $display("FAIL mid_set_wins got=%b exp=1", overflow); end
        // held head while not ready
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        checks++; if (out_data !== sb[0] || out_valid !== 1'b1) begin errors++; $display("FAIL mid_stable got=%h exp=%h", out_data, sb[0]); end
        drain("mid");
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        ovf_m     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        test_reset();
        test_single_pass();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
